// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalise-and-round unit for the FPU add/sub path.
// Stage 1 normalises the raw adder result; stage 2 rounds, saturates and packs.
module fp_norm_round_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANT_W+3:0]         in_mant,
  input  logic                      in_carry,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic                      in_sign,
  input  logic [1:0]                in_rm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W:0]     out_r,
  output logic [3:0]                out_flags
);

  localparam int MW  = MANT_W + 4;
  localparam int XW  = EXP_W + 2;
  localparam int LZW = $clog2(MW + 1);
  localparam logic signed [XW-1:0] EXP_ALL1 = XW'((2 ** EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  logic                 s1_valid;
  logic [MW-1:0]        s1_mant;
  logic signed [XW-1:0] s1_exp;
  logic                 s1_sign;
  logic [1:0]           s1_rm;
  logic                 s1_zero;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  logic [LZW-1:0]       lz;
  logic                 lz_found;
  logic [MW-1:0]        norm_mant;
  logic signed [XW-1:0] norm_exp;
  logic                 norm_zero;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (in_mant[i]) lz_found = 1'b1;
        else            lz = lz + LZW'(1);
      end
    end
  end

  always_comb begin
    norm_mant = in_mant << lz;
    norm_exp  = XW'(in_exp) - XW'(lz);
    norm_zero = 1'b0;
    if (in_carry) begin
      // carry becomes the hidden bit; the bit shifted out folds into sticky
      norm_mant = {1'b1, in_mant[MW-1:2], in_mant[1] | in_mant[0]};
      norm_exp  = XW'(in_exp) + XW'(1);
    end else if (in_mant == '0) begin
      norm_mant = '0;
      norm_exp  = '0;
      norm_zero = 1'b1;
    end
  end

  logic                 inexact;
  logic                 rnd_inc;
  logic [MANT_W+1:0]    rnd_sum;
  logic signed [XW-1:0] rnd_exp;
  logic [MANT_W-1:0]    rnd_frac;
  logic                 to_inf;
  logic [EXP_W+MANT_W:0] res_r;
  logic [3:0]           res_f;

  assign inexact = |s1_mant[2:0];

  always_comb begin
    unique case (s1_rm)
      RM_RNE:  rnd_inc = s1_mant[2] & (s1_mant[1] | s1_mant[0] | s1_mant[3]);
      RM_RTZ:  rnd_inc = 1'b0;
      RM_RUP:  rnd_inc = ~s1_sign & inexact;
      RM_RDN:  rnd_inc = s1_sign & inexact;
      default: rnd_inc = 1'b0;
    endcase
  end

  assign rnd_sum  = {1'b0, s1_mant[MW-1:3]} + (MANT_W+2)'(rnd_inc);
  // top two sum bits are 2'b01 normally and 2'b10 on round carry: exp += top-1
  assign rnd_exp  = s1_exp + XW'(rnd_sum[MANT_W+1:MANT_W]) - XW'(1);
  assign rnd_frac = rnd_sum[MANT_W+1] ? '0 : rnd_sum[MANT_W-1:0];

  always_comb begin
    to_inf = 1'b0;
    unique case (s1_rm)
      RM_RNE:  to_inf = 1'b1;
      RM_RTZ:  to_inf = 1'b0;
      RM_RUP:  to_inf = ~s1_sign;
      RM_RDN:  to_inf = s1_sign;
      default: to_inf = 1'b0;
    endcase
  end

  always_comb begin
    res_r = {s1_sign, rnd_exp[EXP_W-1:0], rnd_frac};
    res_f = {2'b00, inexact, 1'b0};
    if (s1_zero) begin
      res_r = {s1_sign, {(EXP_W+MANT_W){1'b0}}};
      res_f = 4'b0001;
    end else if (rnd_exp >= EXP_ALL1) begin
      res_f = 4'b1010;
      if (to_inf) res_r = {s1_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      else        res_r = {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
    end else if (rnd_exp <= EXP_ZERO) begin
      res_r = {s1_sign, {(EXP_W+MANT_W){1'b0}}};
      res_f = 4'b0111;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_mant   <= '0;
      s1_exp    <= '0;
      s1_sign   <= 1'b0;
      s1_rm     <= '0;
      s1_zero   <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_flags <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mant <= norm_mant;
          s1_exp  <= norm_exp;
          s1_sign <= in_sign;
          s1_rm   <= in_rm;
          s1_zero <= norm_zero;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_r     <= res_r;
          out_flags <= res_f;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Bench for fp_norm_round_pipe: directed vectors with literal expectations,
// an arithmetic reference model and a per-cycle output compare.
module tb_fp_norm_round_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_mant;
  logic        in_carry;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic [1:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic [3:0]  out_flags;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];

  fp_norm_round_pipe #(.EXP_W(8), .MANT_W(23)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_carry(in_carry), .in_exp(in_exp),
    .in_sign(in_sign), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  // Value = {carry, mant} * 2^(exp-26); round to 24 significant bits.
  function automatic logic [35:0] model(input logic [26:0] m, input logic c,
                                        input logic [7:0] ex, input logic s,
                                        input logic [1:0] rm);
    longint v, q, rem, half;
    int p, e;
    logic inc, inx, big;
    v = longint'({c, m});
    if (v == 0) return {s, 31'h0, 4'b0001};
    p = 0;
    for (int i = 0; i < 28; i++) if (v[i]) p = i;
    e = int'(ex) + p - 26;
    if (p > 23) begin
      q    = v >> (p - 23);
      rem  = v - (q << (p - 23));
      half = longint'(1) << (p - 24);
    end else begin
      q    = v << (23 - p);
      rem  = 0;
      half = 1;
    end
    inx = (rem != 0);
    case (rm)
      2'd0:    inc = (rem > half) || (rem == half && q[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = !s && inx;
      default: inc = s && inx;
    endcase
    q = q + longint'(inc);
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      big = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
      return big ? {s, 8'hFF, 23'h0, 4'b1010} : {s, 8'hFE, 23'h7FFFFF, 4'b1010};
    end
    if (e <= 0) return {s, 31'h0, 4'b0111};
    return {s, e[7:0], q[22:0], 2'b00, inx, 1'b0};
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic send(input logic [26:0] m, input logic c, input logic [7:0] ex,
                      input logic s, input logic [1:0] rm,
                      input logic [31:0] lit_r, input logic [3:0] lit_f);
    logic [35:0] mv;
    bit acc;
    int t;
    mv = model(m, c, ex, s, rm);
    check("model_pin", mv, {lit_r, lit_f});
    in_valid = 1'b1;
    in_mant  = m;
    in_carry = c;
    in_exp   = ex;
    in_sign  = s;
    in_rm    = rm;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      t++;
    end
    if (acc) begin
      exp_q.push_back(mv);
      n_vec++;
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    idle();
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 36'(exp_q.size()), 36'd0);
  endtask

  always @(posedge clk)
    if (!reset && out_valid && out_ready && exp_q.size() != 0)
      void'(exp_q.pop_front());

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL stale_out: got %h/%b, expected no output", out_r, out_flags);
      end else begin
        check("out", {out_r, out_flags}, exp_q[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_carry  = 1'b0;
    in_exp    = '0;
    in_sign   = 1'b0;
    in_rm     = 2'b00;
    out_ready = 1'b1;
    #1;
    check("rst_state", {out_r, out_flags}, 36'h0);
    check("rst_valid", 36'(out_valid), 36'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 36'(in_ready), 36'd1);

    // latency: present in cycle c, output valid in cycle c+2
    send(27'h4000000, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h3F800000, 4'b0000);
    idle();
    check("lat_early", 36'(out_valid), 36'd0);
    @(posedge clk);
    #1;
    check("lat_on_time", 36'(out_valid), 36'd1);
    drain();

    // rounding modes
    send(27'h400000C, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h3F800002, 4'b0010);
    send(27'h4000004, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h3F800000, 4'b0010);
    send(27'h4000004, 1'b0, 8'h7F, 1'b0, 2'd2, 32'h3F800001, 4'b0010);
    send(27'h4000004, 1'b0, 8'h7F, 1'b1, 2'd3, 32'hBF800001, 4'b0010);
    send(27'h4000004, 1'b0, 8'h7F, 1'b1, 2'd1, 32'hBF800000, 4'b0010);
    // round carry and adder carry
    send(27'h7FFFFFE, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h40000000, 4'b0010);
    send(27'h0000000, 1'b1, 8'h7F, 1'b0, 2'd0, 32'h40000000, 4'b0000);
    send(27'h0000001, 1'b1, 8'h7F, 1'b0, 2'd2, 32'h40000001, 4'b0010);
    // normalisation, zero, underflow boundary
    send(27'h0000008, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h34000000, 4'b0000);
    send(27'h2000000, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h3F000000, 4'b0000);
    send(27'h0000000, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h00000000, 4'b0001);
    send(27'h0000000, 1'b0, 8'h7F, 1'b1, 2'd0, 32'h80000000, 4'b0001);
    send(27'h0000008, 1'b0, 8'h10, 1'b0, 2'd0, 32'h00000000, 4'b0111);
    send(27'h4000000, 1'b0, 8'h01, 1'b0, 2'd0, 32'h00800000, 4'b0000);
    send(27'h2000000, 1'b0, 8'h01, 1'b1, 2'd0, 32'h80000000, 4'b0111);
    // overflow boundary and saturation per mode
    send(27'h4000000, 1'b0, 8'hFE, 1'b0, 2'd0, 32'h7F000000, 4'b0000);
    send(27'h0000000, 1'b1, 8'hFE, 1'b0, 2'd0, 32'h7F800000, 4'b1010);
    send(27'h0000000, 1'b1, 8'hFE, 1'b0, 2'd1, 32'h7F7FFFFF, 4'b1010);
    send(27'h0000000, 1'b1, 8'hFE, 1'b1, 2'd3, 32'hFF800000, 4'b1010);
    send(27'h0000000, 1'b1, 8'hFE, 1'b1, 2'd2, 32'hFF7FFFFF, 4'b1010);
    send(27'h7FFFFFE, 1'b0, 8'hFE, 1'b0, 2'd0, 32'h7F800000, 4'b1010);
    drain();

    // backpressure: downstream stalls 4 cycles while 5 beats stream in
    out_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send(27'h4000000, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h3F800000, 4'b0000);
    send(27'h400000C, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h3F800002, 4'b0010);
    check("bp_in_ready", 36'(in_ready), 36'd0);
    @(posedge clk);
    #1;
    check("bp_hold", {out_r, out_flags}, {32'h3F800000, 4'b0000});
    check("bp_hold_valid", 36'(out_valid), 36'd1);
    send(27'h0000008, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h34000000, 4'b0000);
    send(27'h0000000, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h00000000, 4'b0001);
    send(27'h0000000, 1'b1, 8'hFE, 1'b0, 2'd0, 32'h7F800000, 4'b1010);
    drain();

    // reset with two beats in flight
    out_ready = 1'b0;
    send(27'h4000000, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h3F800000, 4'b0000);
    send(27'h0000008, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h34000000, 4'b0000);
    idle();
    @(negedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_valid", 36'(out_valid), 36'd0);
    check("rst_mid_out", {out_r, out_flags}, 36'h0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_stale", 36'(out_valid), 36'd0);
    check("rst_ready_after", 36'(in_ready), 36'd1);

    // pipeline still works after reset
    send(27'h400000C, 1'b0, 8'h7F, 1'b0, 2'd0, 32'h3F800002, 4'b0010);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
